sort_seq: RTL

Sequential sorting engine for signed words, built around a single shared `comparator_lt` instance.
- Accepts a burst of K two's-complement words on a valid/ready input stream.
- Sorts them in place, ascending, with a fixed-schedule bubble sort of one compare-and-swap per cycle.
- Streams the sorted result out on a valid/ready output.
- Serves as the scheduling/control layer that time-multiplexes one comparator across all element pairs.

---
 rtl/sort_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sort_seq.sv
// Sequential ascending sort of K signed words via one time-shared comparator.
// Latency: first output (K-1)^2+1 cycles after the last input accept.
// Backpressure: in_ready only in LOAD; DRAIN holds out_data/out_last while out_ready is low.

module comparator_lt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);
    assign lt = $signed(a) < $signed(b);
endmodule

module sort_seq #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic [$clog2(K*K):0]    swap_count
);
    localparam int IW = (K > 2) ? $clog2(K) : 1;
    localparam int SW = $clog2(K*K) + 1;
    localparam logic [IW-1:0] LAST_W = IW'(K-1);
    localparam logic [IW-1:0] LAST_I = IW'(K-2);

    typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_t;

    state_t          state, state_nx;
    logic [N-1:0]    sbuf [K];
    logic [IW-1:0]   wr, idx, pass, rd;
    logic [IW-1:0]   idx_p1;
    logic            lt;

    assign idx_p1 = idx + IW'(1);

    comparator_lt #(.N(N)) u_cmp (
        .a  (sbuf[idx_p1]),
        .b  (sbuf[idx]),
        .lt (lt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_LOAD;
        else      state <= state_nx;
    end

    // Outputs depend only on registered state; handshakes only steer next state.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && wr == LAST_W) state_nx = S_SORT;
            end
            S_SORT: begin
                busy = 1'b1;
                if (idx == LAST_I && pass == LAST_I) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = sbuf[rd];
                out_last  = (rd == LAST_W);
                if (out_ready && rd == LAST_W) state_nx = S_LOAD;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < K; i++) sbuf[i] <= '0;
            wr         <= '0;
            idx        <= '0;
            pass       <= '0;
            rd         <= '0;
            swap_count <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        sbuf[wr] <= in_data;
                        if (wr == LAST_W) begin
                            wr         <= '0;
                            idx        <= '0;
                            pass       <= '0;
                            swap_count <= '0;
                        end else begin
                            wr <= wr + IW'(1);
                        end
                    end
                end
                S_SORT: begin
                    // Strict less-than keeps equal words in arrival order.
                    if (lt) begin
                        sbuf[idx]    <= sbuf[idx_p1];
                        sbuf[idx_p1] <= sbuf[idx];
                        swap_count   <= swap_count + SW'(1);
                    end
                    if (idx == LAST_I) begin
                        idx <= '0;
                        if (pass == LAST_I) begin
                            pass <= '0;
                            rd   <= '0;
                        end else begin
                            pass <= pass + IW'(1);
                        end
                    end else begin
                        idx <= idx_p1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (rd == LAST_W) begin
                            rd <= '0;
                            wr <= '0;
                        end else begin
                            rd <= rd + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
